// File: rtl/pulse_event_arbiter.sv
// Latches one-clock request pulses per channel and hands them out round-robin as event IDs.
// Pulse to valid is two cycles; a held-off offer keeps its ID stable, and repeat pulses set sticky overflow.
module pulse_event_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] pulse_i,
  input  logic [N_REQ-1:0] mask_i,
  output logic             event_valid_o,
  input  logic             event_ready_i,
  output logic [IDW-1:0]   event_id_o,
  output logic [N_REQ-1:0] pending_o,
  output logic [N_REQ-1:0] overflow_o,
  input  logic             overflow_clr_i
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic [IDW-1:0]   last_grant;
  logic             consume;
  logic [N_REQ-1:0] consume_vec;
  logic [N_REQ-1:0] accept;
  logic [N_REQ-1:0] pending_nxt;
  logic [N_REQ-1:0] overflow_nxt;
  logic             sel_found;
  logic [IDW-1:0]   sel_id;

  // A handshake frees the slot on the same edge, so a coincident pulse re-arms rather than overflows.
  always_comb begin
    consume      = (state == OFFER) && event_ready_i;
    consume_vec  = consume ? (N_REQ'(1) << event_id_o) : '0;
    accept       = pulse_i & mask_i;
    pending_nxt  = (pending_o & ~consume_vec) | accept;
    overflow_nxt = (overflow_o & ~{N_REQ{overflow_clr_i}})
                 | (accept & pending_o & ~consume_vec);
  end

  // Walk downward so the closest channel after last_grant is the final (winning) assignment.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_w;
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = 0;
    idx_w     = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx   = (int'(last_grant) + i) % N_REQ;
      idx_w = IDW'(idx);
      if (pending_o[idx_w]) begin
        sel_found = 1'b1;
        sel_id    = idx_w;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      event_valid_o <= 1'b0;
      event_id_o    <= '0;
      last_grant    <= IDW'(N_REQ - 1);
      pending_o     <= '0;
      overflow_o    <= '0;
    end else begin
      pending_o  <= pending_nxt;
      overflow_o <= overflow_nxt;
      case (state)
        IDLE: begin
          if (sel_found) begin
            event_id_o    <= sel_id;
            event_valid_o <= 1'b1;
            state         <= OFFER;
          end
        end
        OFFER: begin
          if (event_ready_i) begin
            last_grant    <= event_id_o;
            event_valid_o <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          event_valid_o <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter: reset, ordering, round-robin, backpressure, overflow, mask, re-arm.
module tb_pulse_event_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] pulse;
  logic [3:0] mask;
  logic       valid;
  logic       ready;
  logic [1:0] id;
  logic [3:0] pending;
  logic [3:0] overflow;
  logic       clr;

  int total = 0;
  int bad   = 0;

  pulse_event_arbiter #(.N_REQ(4)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pulse_i       (pulse),
    .mask_i        (mask),
    .event_valid_o (valid),
    .event_ready_i (ready),
    .event_id_o    (id),
    .pending_o     (pending),
    .overflow_o    (overflow),
    .overflow_clr_i(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [1:0] i,
                         input logic [3:0] p, input logic [3:0] o);
    chk({tag, ".valid"}, {7'd0, valid}, {7'd0, v});
    chk({tag, ".id"}, {6'd0, id}, {6'd0, i});
    chk({tag, ".pending"}, {4'd0, pending}, {4'd0, p});
    chk({tag, ".overflow"}, {4'd0, overflow}, {4'd0, o});
  endtask

  initial begin
    rst = 1'b1; pulse = 4'b1111; mask = 4'b1111; ready = 1'b1; clr = 1'b0;

    // reset held two edges with all pulses high
    tick(); chk_all("rst1", 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(); chk_all("rst2", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst = 1'b0; pulse = 4'b0000;
    tick(); chk_all("rel1", 1'b0, 2'd0, 4'b0000, 4'b0000);
    tick(); chk_all("rel2", 1'b0, 2'd0, 4'b0000, 4'b0000);

    // simultaneous 1011 from fresh reset: 0,1,3
    pulse = 4'b1011;
    tick(); chk_all("sim.lat", 1'b0, 2'd0, 4'b1011, 4'b0000);
    pulse = 4'b0000;
    tick(); chk_all("sim.g0", 1'b1, 2'd0, 4'b1011, 4'b0000);
    tick(); chk_all("sim.gap0", 1'b0, 2'd0, 4'b1010, 4'b0000);
    tick(); chk_all("sim.g1", 1'b1, 2'd1, 4'b1010, 4'b0000);
    tick(); chk_all("sim.gap1", 1'b0, 2'd1, 4'b1000, 4'b0000);
    tick(); chk_all("sim.g3", 1'b1, 2'd3, 4'b1000, 4'b0000);
    tick(); chk_all("sim.done", 1'b0, 2'd3, 4'b0000, 4'b0000);

    // single request on channel 2
    pulse = 4'b0100;
    tick(); chk_all("one.pend", 1'b0, 2'd3, 4'b0100, 4'b0000);
    pulse = 4'b0000;
    tick(); chk_all("one.offer", 1'b1, 2'd2, 4'b0100, 4'b0000);
    tick(); chk_all("one.done", 1'b0, 2'd2, 4'b0000, 4'b0000);
    tick(); chk("one.quiet", {7'd0, valid}, 8'd0);

    // round-robin: grant 0, then 0+1 together -> 1 then 0
    pulse = 4'b0001;
    tick(); pulse = 4'b0000;
    tick(); chk_all("rr.g0", 1'b1, 2'd0, 4'b0001, 4'b0000);
    tick(); chk("rr.gap", {7'd0, valid}, 8'd0);
    pulse = 4'b0011;
    tick(); chk("rr.pend", {4'd0, pending}, 8'h03);
    pulse = 4'b0000;
    tick(); chk_all("rr.g1", 1'b1, 2'd1, 4'b0011, 4'b0000);
    tick(); chk("rr.gap2", {7'd0, valid}, 8'd0);
    tick(); chk_all("rr.g0b", 1'b1, 2'd0, 4'b0001, 4'b0000);
    tick(); chk_all("rr.done", 1'b0, 2'd0, 4'b0000, 4'b0000);

    // backpressure and overflow on channel 1
    ready = 1'b0; pulse = 4'b0010;
    tick(); pulse = 4'b0000;
    tick(); chk_all("bp.offer", 1'b1, 2'd1, 4'b0010, 4'b0000);
    pulse = 4'b0010;
    tick(); chk_all("bp.ovf", 1'b1, 2'd1, 4'b0010, 4'b0010);
    pulse = 4'b0000;
    tick(); chk_all("bp.hold", 1'b1, 2'd1, 4'b0010, 4'b0010);
    clr = 1'b1;
    tick(); chk_all("bp.clr", 1'b1, 2'd1, 4'b0010, 4'b0000);
    pulse = 4'b0010;
    tick(); chk_all("bp.clrset", 1'b1, 2'd1, 4'b0010, 4'b0010);
    clr = 1'b0; pulse = 4'b0000; ready = 1'b1;
    tick(); chk_all("bp.take", 1'b0, 2'd1, 4'b0000, 4'b0010);
    clr = 1'b1;
    tick(); chk("bp.clr2", {4'd0, overflow}, 8'h00);
    clr = 1'b0;

    // masked channel 3 is ignored
    mask = 4'b0111; pulse = 4'b1000;
    tick(); chk("mask.pend", {4'd0, pending}, 8'h00);
    pulse = 4'b0000;
    tick(); chk("mask.novld", {7'd0, valid}, 8'd0);

    // masking after latching keeps the request
    mask = 4'b1111; pulse = 4'b1000;
    tick(); chk("mask.late.pend", {4'd0, pending}, 8'h08);
    mask = 4'b0111; pulse = 4'b0000;
    tick(); chk_all("mask.late.g3", 1'b1, 2'd3, 4'b1000, 4'b0000);
    tick(); chk_all("mask.late.done", 1'b0, 2'd3, 4'b0000, 4'b0000);
    mask = 4'b1111;

    // re-arm: pulse channel 2 on its own handshake edge
    pulse = 4'b0100;
    tick(); pulse = 4'b0000;
    tick(); chk_all("rearm.g2", 1'b1, 2'd2, 4'b0100, 4'b0000);
    pulse = 4'b0100;
    tick(); chk_all("rearm.hs", 1'b0, 2'd2, 4'b0100, 4'b0000);
    pulse = 4'b0000;
    tick(); chk_all("rearm.g2b", 1'b1, 2'd2, 4'b0100, 4'b0000);
    tick(); chk_all("rearm.done", 1'b0, 2'd2, 4'b0000, 4'b0000);

    // reset mid-offer discards everything
    ready = 1'b0; pulse = 4'b0011;
    tick(); pulse = 4'b0000;
    tick(); chk("mid.offer", {7'd0, valid}, 8'd1);
    rst = 1'b1;
    tick(); chk_all("mid.rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
    rst = 1'b0; ready = 1'b1;
    tick(); tick(); chk("mid.quiet", {7'd0, valid}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
